// File: rtl/fft_io_sequencer.sv
// fft_io_sequencer: host-side frame sequencer for the 2048-point FFT core.
// It loads 2048 real samples into RAM A through the core's external write
// ports, then pulses start and waits for a rising edge on iFFT_RDY. After
// that it streams the 2048 results out over a valid/ready/last interface.
// Optional feature: define FFT_IO_TIMEOUT_EN to build the RUN timeout
// counter and the ERR state. The timeout length is set by TIMEOUT_CYCLES.
module fft_io_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic        iABORT,
  input  logic [15:0] iIN_DATA,
  input  logic        iIN_VALID,
  output logic        oIN_READY,
  output logic [15:0] oFFT_DATA,
  output logic [8:0]  oFFT_ADDR_WR,
  output logic [3:0]  oFFT_WE,
  output logic [8:0]  oFFT_ADDR_RD,
  output logic        oFFT_START,
  input  logic        iFFT_RDY,
  input  logic [16:0] iFFT_RE_0,
  input  logic [16:0] iFFT_RE_1,
  input  logic [16:0] iFFT_RE_2,
  input  logic [16:0] iFFT_RE_3,
  output logic [16:0] oOUT_DATA,
  output logic        oOUT_VALID,
  input  logic        iOUT_READY,
  output logic        oOUT_LAST,
  output logic        oBUSY,
  output logic        oFRAME_DONE,
  output logic        oERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_RD,
    S_CAP,
    S_EMIT
`ifdef FFT_IO_TIMEOUT_EN
    , S_ERR
`endif
  } state_t;

  state_t      state_q;
  logic [10:0] n_q;
  logic [10:0] k_q;
  logic [10:0] k_inc;
  logic [15:0] data_q;
  logic [8:0]  addr_wr_q;
  logic [3:0]  we_q;
  logic [8:0]  addr_rd_q;
  logic        start_q;
  logic        out_valid_q;
  logic        done_q;
  logic        rdy_prev_q;
  logic [16:0] buf_q [4];

`ifdef FFT_IO_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_q;
`endif

  assign k_inc = k_q + 11'd1;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      k_q         <= '0;
      data_q      <= '0;
      addr_wr_q   <= '0;
      we_q        <= '0;
      addr_rd_q   <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      rdy_prev_q  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) buf_q[i] <= '0;
`ifdef FFT_IO_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else if (iABORT) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      k_q         <= '0;
      data_q      <= '0;
      addr_wr_q   <= '0;
      we_q        <= '0;
      addr_rd_q   <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      rdy_prev_q  <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) buf_q[i] <= '0;
`ifdef FFT_IO_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      we_q    <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (iIN_VALID) begin
            data_q    <= iIN_DATA;
            addr_wr_q <= n_q[10:2];
            we_q      <= 4'b0001 << n_q[1:0];
            n_q       <= n_q + 11'd1;
            if (n_q == 11'd2047) begin
              state_q <= S_START;
              start_q <= 1'b1;
            end else begin
              state_q <= S_LOAD;
            end
          end
        end
        // Detector armed high so RUN must see a low before a high
        S_START: begin
          state_q    <= S_RUN;
          rdy_prev_q <= 1'b1;
`ifdef FFT_IO_TIMEOUT_EN
          tmo_q      <= '0;
`endif
        end
        S_RUN: begin
          rdy_prev_q <= iFFT_RDY;
          if (!rdy_prev_q && iFFT_RDY) begin
            k_q       <= '0;
            addr_rd_q <= '0;
            state_q   <= S_RD;
          end
`ifdef FFT_IO_TIMEOUT_EN
          else if (tmo_q == TMO_LAST) begin
            state_q <= S_ERR;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
`endif
        end
        S_RD: begin
          state_q <= S_CAP;
        end
        S_CAP: begin
          buf_q[0]    <= iFFT_RE_0;
          buf_q[1]    <= iFFT_RE_1;
          buf_q[2]    <= iFFT_RE_2;
          buf_q[3]    <= iFFT_RE_3;
          out_valid_q <= 1'b1;
          state_q     <= S_EMIT;
        end
        S_EMIT: begin
          if (iOUT_READY) begin
            k_q <= k_inc;
            if (k_q[1:0] == 2'd3) begin
              out_valid_q <= 1'b0;
              if (k_q == 11'd2047) begin
                done_q  <= 1'b1;
                state_q <= S_IDLE;
              end else begin
                addr_rd_q <= k_inc[10:2];
                state_q   <= S_RD;
              end
            end
          end
        end
`ifdef FFT_IO_TIMEOUT_EN
        S_ERR: begin
          state_q <= S_ERR;
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oIN_READY    = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign oFFT_DATA    = data_q;
  assign oFFT_ADDR_WR = addr_wr_q;
  assign oFFT_WE      = we_q;
  assign oFFT_ADDR_RD = addr_rd_q;
  assign oFFT_START   = start_q;
  assign oOUT_DATA    = buf_q[k_q[1:0]];
  assign oOUT_VALID   = out_valid_q;
  assign oOUT_LAST    = out_valid_q && (k_q == 11'd2047);
  assign oBUSY        = (state_q != S_IDLE);
  assign oFRAME_DONE  = done_q;
`ifdef FFT_IO_TIMEOUT_EN
  assign oERR         = (state_q == S_ERR);
`else
  assign oERR         = 1'b0;
`endif

endmodule
